// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, the buffered write-back entry type and starvation FSM states
// for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

  typedef struct packed {
    reg_idx_t idx;
    xlen_t    data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StHold  = 2'd2
  } starve_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the core (master) and the write-port arbiter (slave):
// writeback port, coprocessor result return, decode hazard query and regfile write.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic     pipe_wr_en;
  reg_idx_t pipe_wr_idx;
  xlen_t    pipe_wr_data;
  logic     cop_valid;
  logic     cop_ready;
  reg_idx_t cop_wr_idx;
  xlen_t    cop_wr_data;
  logic     cop_issue;
  reg_idx_t dec_rs1;
  reg_idx_t dec_rs2;
  reg_idx_t dec_rd;
  logic     dec_rd_we;
  logic     dec_is_cop;
  logic     dec_stall;
  logic     hold_req;
  logic     reg_write;
  reg_idx_t wr_idx;
  xlen_t    wr_data;

  modport master (
    output pipe_wr_en, pipe_wr_idx, pipe_wr_data,
    output cop_valid, cop_wr_idx, cop_wr_data, cop_issue,
    output dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_is_cop,
    input  cop_ready, dec_stall, hold_req, reg_write, wr_idx, wr_data
  );

  modport slave (
    input  pipe_wr_en, pipe_wr_idx, pipe_wr_data,
    input  cop_valid, cop_wr_idx, cop_wr_data, cop_issue,
    input  dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_is_cop,
    output cop_ready, dec_stall, hold_req, reg_write, wr_idx, wr_data
  );

endinterface

// File: rtl/wb_port_arbiter_sync_fifo.sv
// Single-clock FIFO with first-word-visible head; Depth must be a power of two
// so the pointers wrap naturally.
module wb_port_arbiter_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_data,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between pipeline writeback and buffered coprocessor
// results; tracks in-flight coprocessor destinations to stall decode on hazards.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  localparam int unsigned OutW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t         w_push_entry;
  wb_entry_t         w_head;
  logic              w_full;
  logic              w_empty;
  logic [CntW-1:0]   w_count;
  logic              w_pipe_active;
  logic              w_pop;
  logic              w_push;
  logic              w_blocked;
  logic [31:0]       w_pending_nxt;

  logic [31:0]       r_pending;
  logic [OutW-1:0]   r_outstanding;
  starve_state_e     r_state;
  logic [StarveW-1:0] r_starve_cnt;
  logic              r_hold_req;

  assign w_pipe_active = bus.pipe_wr_en & (bus.pipe_wr_idx != '0);
  assign w_pop         = ~w_pipe_active & ~w_empty;
  assign w_push        = bus.cop_valid & ~w_full;
  assign w_blocked     = ~w_empty & w_pipe_active;
  assign w_push_entry  = '{idx: bus.cop_wr_idx, data: bus.cop_wr_data};
  assign bus.cop_ready = ~w_full;
  assign bus.hold_req  = r_hold_req;

  wb_port_arbiter_sync_fifo #(
    .Width ($bits(wb_entry_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Pipeline writeback has priority; a popped x0 result is discarded silently.
  always_comb begin
    bus.reg_write = 1'b0;
    bus.wr_idx    = '0;
    bus.wr_data   = '0;
    if (w_pipe_active) begin
      bus.reg_write = 1'b1;
      bus.wr_idx    = bus.pipe_wr_idx;
      bus.wr_data   = bus.pipe_wr_data;
    end else if (w_pop) begin
      bus.reg_write = (w_head.idx != '0);
      bus.wr_idx    = w_head.idx;
      bus.wr_data   = w_head.data;
    end
  end

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.idx] = 1'b0;
    if (bus.cop_issue && (bus.dec_rd != '0)) w_pending_nxt[bus.dec_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  assign bus.dec_stall = r_pending[bus.dec_rs1] | r_pending[bus.dec_rs2] |
                         (bus.dec_rd_we & r_pending[bus.dec_rd]) |
                         (bus.dec_is_cop & (r_outstanding == OutW'(MAX_OUTSTANDING)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending     <= '0;
      r_outstanding <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      case ({bus.cop_issue, w_pop})
        2'b10:   r_outstanding <= r_outstanding + OutW'(1);
        2'b01:   r_outstanding <= r_outstanding - OutW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Counts consecutive cycles in which a buffered result loses to the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_starve_cnt <= '0;
      r_hold_req   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_blocked) begin
            r_starve_cnt <= StarveW'(1);
            if (STARVE_LIMIT <= 1) begin
              r_state    <= StHold;
              r_hold_req <= 1'b1;
            end else begin
              r_state <= StCount;
            end
          end
        end
        StCount: begin
          if (!w_blocked) begin
            r_state      <= StIdle;
            r_starve_cnt <= '0;
          end else begin
            r_starve_cnt <= r_starve_cnt + StarveW'(1);
            if (r_starve_cnt + StarveW'(1) >= StarveW'(STARVE_LIMIT)) begin
              r_state    <= StHold;
              r_hold_req <= 1'b1;
            end
          end
        end
        StHold: begin
          if (!w_blocked) begin
            r_state      <= StIdle;
            r_starve_cnt <= '0;
            r_hold_req   <= 1'b0;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_starve_cnt <= '0;
          r_hold_req   <= 1'b0;
        end
      endcase
    end
  end

  // Every buffered result belongs to an op that is still counted as outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(bus.cop_issue && !w_pop && (r_outstanding == OutW'(MAX_OUTSTANDING))));
      assert (!(w_pop && !bus.cop_issue && (r_outstanding == '0)));
      assert (int'(r_outstanding) >= int'(w_count));
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against a queue-based behavioural model of the write-port arbiter.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int unsigned FifoDepth   = 4;
  localparam int unsigned MaxOut      = 4;
  localparam int unsigned StarveLimit = 8;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wb_port_arbiter_if bus();

  wb_port_arbiter #(
    .FIFO_DEPTH      (FifoDepth),
    .MAX_OUTSTANDING (MaxOut),
    .STARVE_LIMIT    (StarveLimit)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ent_t       m_q[$];
  bit         m_pend[32];
  int         m_out;
  int         m_run;
  logic [4:0] inflight[$];
  bit         chk_en = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int m_size();
    return rst ? m_q.size() : 0;
  endfunction

  function automatic bit m_pipe_active();
    return bus.pipe_wr_en && (bus.pipe_wr_idx != 5'd0);
  endfunction

  function automatic bit m_stall();
    if (!rst) return 1'b0;
    return m_pend[bus.dec_rs1] || m_pend[bus.dec_rs2] ||
           (bus.dec_rd_we && m_pend[bus.dec_rd]) ||
           (bus.dec_is_cop && (m_out == MaxOut));
  endfunction

  function automatic bit m_hold();
    return rst && (m_run >= StarveLimit);
  endfunction

  // Model state advances on the edge using the inputs that were held for the cycle.
  always @(posedge clk) begin : model_update
    bit   active, pop, push;
    int   sz;
    ent_t head;
    if (!rst) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_out = 0;
      m_run = 0;
    end else begin
      active = m_pipe_active();
      sz     = m_q.size();
      pop    = !active && (sz > 0);
      push   = bus.cop_valid && (sz < FifoDepth);
      if (pop) begin
        head = m_q.pop_front();
        m_pend[head.idx] = 1'b0;
      end
      if (bus.cop_issue && (bus.dec_rd != 5'd0)) m_pend[bus.dec_rd] = 1'b1;
      m_out = m_out + int'(bus.cop_issue) - int'(pop);
      if ((sz > 0) && active) m_run++;
      else m_run = 0;
      if (push) m_q.push_back('{idx: bus.cop_wr_idx, data: bus.cop_wr_data});
    end
  end

  always @(negedge clk) begin : compare
    logic        e_rw;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
    if (chk_en) begin
      #2;
      e_rw = 1'b0; e_idx = 5'd0; e_data = 32'd0;
      if (m_pipe_active()) begin
        e_rw = 1'b1; e_idx = bus.pipe_wr_idx; e_data = bus.pipe_wr_data;
      end else if (m_size() > 0) begin
        e_rw = (m_q[0].idx != 5'd0); e_idx = m_q[0].idx; e_data = m_q[0].data;
      end
      check("reg_write", 32'(bus.reg_write), 32'(e_rw));
      if (e_rw) begin
        check("wr_idx", 32'(bus.wr_idx), 32'(e_idx));
        check("wr_data", bus.wr_data, e_data);
      end
      check("cop_ready", 32'(bus.cop_ready), 32'(m_size() < FifoDepth));
      check("dec_stall", 32'(bus.dec_stall), 32'(m_stall()));
      check("hold_req", 32'(bus.hold_req), 32'(m_hold()));
    end
  end

  task automatic drive_idle();
    bus.pipe_wr_en = 1'b0; bus.pipe_wr_idx = 5'd0; bus.pipe_wr_data = 32'd0;
    bus.cop_valid  = 1'b0; bus.cop_wr_idx  = 5'd0; bus.cop_wr_data  = 32'd0;
    bus.cop_issue  = 1'b0;
    bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
    bus.dec_rd_we = 1'b0; bus.dec_is_cop = 1'b0;
  endtask

  task automatic issue_op(input logic [4:0] rd);
    bus.dec_is_cop = 1'b1;
    bus.dec_rd     = rd;
    bus.dec_rd_we  = 1'b1;
    bus.cop_issue  = !m_stall();
  endtask

  task automatic pipe_wr(input logic [4:0] idx, input logic [31:0] data);
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_idx = idx; bus.pipe_wr_data = data;
  endtask

  task automatic cop_res(input logic [4:0] idx, input logic [31:0] data);
    bus.cop_valid = 1'b1; bus.cop_wr_idx = idx; bus.cop_wr_data = data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk); chk_en = 1'b1; #3;
    check("rst reg_write", 32'(bus.reg_write), 32'd0);
    check("rst wr_idx", 32'(bus.wr_idx), 32'd0);
    check("rst wr_data", bus.wr_data, 32'd0);
    check("rst cop_ready", 32'(bus.cop_ready), 32'd1);
    check("rst hold_req", 32'(bus.hold_req), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Pipeline passthrough with an empty FIFO.
    @(negedge clk); drive_idle(); pipe_wr(5'd5, 32'h1234); #3;
    check("pass reg_write", 32'(bus.reg_write), 32'd1);
    check("pass wr_idx", 32'(bus.wr_idx), 32'd5);
    check("pass wr_data", bus.wr_data, 32'h1234);
    check("pass dec_stall", 32'(bus.dec_stall), 32'd0);

    // RAW on x7 held until one cycle after its result is written.
    @(negedge clk); drive_idle(); issue_op(5'd7);
    @(negedge clk); drive_idle(); bus.dec_rs1 = 5'd7; cop_res(5'd7, 32'hA5A5); #3;
    check("raw stall", 32'(bus.dec_stall), 32'd1);
    @(negedge clk); drive_idle(); bus.dec_rs1 = 5'd7; #3;
    check("x7 reg_write", 32'(bus.reg_write), 32'd1);
    check("x7 wr_idx", 32'(bus.wr_idx), 32'd7);
    check("x7 wr_data", bus.wr_data, 32'hA5A5);
    check("raw stall pop", 32'(bus.dec_stall), 32'd1);
    @(negedge clk); drive_idle(); bus.dec_rs1 = 5'd7; #3;
    check("raw released", 32'(bus.dec_stall), 32'd0);

    // Fill the FIFO under continuous writeback and starve it into hold_req.
    for (int rd = 1; rd <= 4; rd++) begin
      @(negedge clk); drive_idle(); issue_op(5'(rd));
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); drive_idle();
      bus.dec_is_cop = 1'b1; bus.dec_rd = 5'd9; bus.dec_rd_we = 1'b1;
      if (c <= 4) cop_res(5'(c), 32'h100 + 32'(c));
      if (c != 11) pipe_wr(5'd10, 32'(c));
      #3;
      if (c == 5) check("full cop_ready", 32'(bus.cop_ready), 32'd0);
      if (c == 9) check("hold before", 32'(bus.hold_req), 32'd0);
      if (c == 10) begin
        check("hold asserted", 32'(bus.hold_req), 32'd1);
        check("max out stall", 32'(bus.dec_stall), 32'd1);
      end
      if (c == 11) begin
        check("bubble reg_write", 32'(bus.reg_write), 32'd1);
        check("bubble wr_idx", 32'(bus.wr_idx), 32'd1);
        check("bubble wr_data", bus.wr_data, 32'h101);
        check("hold in bubble", 32'(bus.hold_req), 32'd1);
      end
      if (c == 12) begin
        check("hold released", 32'(bus.hold_req), 32'd0);
        check("max out released", 32'(bus.dec_stall), 32'd0);
      end
    end
    repeat (4) begin
      @(negedge clk); drive_idle();
    end

    // x0 destinations: no pending bit, popped silently, x0 pipe write yields.
    @(negedge clk); drive_idle(); issue_op(5'd0);
    @(negedge clk); drive_idle(); bus.dec_rd_we = 1'b1; cop_res(5'd0, 32'h55);
    pipe_wr(5'd0, 32'hBEEF); #3;
    check("rd0 no stall", 32'(bus.dec_stall), 32'd0);
    check("x0 pipe ignored", 32'(bus.reg_write), 32'd0);
    @(negedge clk); drive_idle(); issue_op(5'd6); #3;
    check("x0 head dropped", 32'(bus.reg_write), 32'd0);
    @(negedge clk); drive_idle(); cop_res(5'd6, 32'h66);
    @(negedge clk); drive_idle(); pipe_wr(5'd0, 32'hDEAD); bus.dec_rs2 = 5'd6; #3;
    check("x0 pipe head wr", 32'(bus.reg_write), 32'd1);
    check("x0 pipe head idx", 32'(bus.wr_idx), 32'd6);
    check("x0 pipe head data", bus.wr_data, 32'h66);
    check("rs2 stall", 32'(bus.dec_stall), 32'd1);

    // Asynchronous reset with three buffered results.
    for (int rd = 11; rd <= 13; rd++) begin
      @(negedge clk); drive_idle(); issue_op(5'(rd));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_idle(); cop_res(5'(11 + i), 32'hC0 + 32'(i)); pipe_wr(5'd20, 32'd1);
    end
    @(negedge clk); drive_idle(); pipe_wr(5'd20, 32'd2); bus.dec_rs1 = 5'd11; #3;
    check("pre-rst stall", 32'(bus.dec_stall), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0; bus.pipe_wr_en = 1'b0; #1;
    check("arst reg_write", 32'(bus.reg_write), 32'd0);
    check("arst cop_ready", 32'(bus.cop_ready), 32'd1);
    check("arst hold_req", 32'(bus.hold_req), 32'd0);
    check("arst dec_stall", 32'(bus.dec_stall), 32'd0);
    @(negedge clk); drive_idle();
    @(negedge clk); rst = 1'b1;

    // Randomized traffic; the bench acts as core and in-order coprocessor.
    repeat (3000) begin
      @(negedge clk); drive_idle();
      if ((inflight.size() > 0) && ($urandom_range(0, 2) != 0)) begin
        cop_res(inflight[0], $urandom);
        if (m_size() < FifoDepth) void'(inflight.pop_front());
      end
      bus.dec_rs1    = 5'($urandom_range(0, 7));
      bus.dec_rs2    = 5'($urandom_range(0, 7));
      bus.dec_rd     = 5'($urandom_range(0, 7));
      bus.dec_rd_we  = 1'($urandom_range(0, 1));
      bus.dec_is_cop = ($urandom_range(0, 2) == 0);
      bus.cop_issue  = bus.dec_is_cop && !m_stall();
      if (bus.cop_issue) inflight.push_back(bus.dec_rd);
      if (!m_hold() && ($urandom_range(0, 3) != 0)) pipe_wr(5'($urandom_range(0, 31)), $urandom);
    end
    @(negedge clk); drive_idle();
    @(negedge clk); chk_en = 1'b0;
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
